// File: rtl/banded_sw_aligner.sv
// Banded Smith-Waterman local aligner for two N-base DNA sequences.
// Fills the banded DP matrix one cell per clock, then traces back from the
// best cell, emitting one aligned symbol pair per clock.
// Optional macro BSW_SCORE_PORT_EN adds the best_score output port.
module banded_sw_aligner #(
    parameter int N        = 8,
    parameter int BAND     = 2,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3*N-1:0]          R,
    input  logic [3*N-1:0]          Q,
    output logic [3*(N+BAND)-1:0]   R_aligned,
    output logic [3*(N+BAND)-1:0]   Q_aligned,
    output logic                    ready,
`ifdef BSW_SCORE_PORT_EN
    output logic [7:0]              best_score,
`endif
    output logic [7:0]              pe_mem
);

    localparam int IW = $clog2(N + 1);
    localparam int AL = N + BAND;
    localparam int AW = 3 * AL;
    localparam int CW = $clog2(AL + 1);

    localparam logic [1:0] P_STOP = 2'b00;
    localparam logic [1:0] P_DIAG = 2'b01;
    localparam logic [1:0] P_UP   = 2'b10;
    localparam logic [1:0] P_LEFT = 2'b11;

    localparam logic [2:0] SYM_GAP = 3'b100;
    localparam logic [2:0] SYM_PAD = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_TRACE, S_DONE} state_t;

    state_t r_state, w_state_next;

    // Latched sequences and DP storage (row/column 0 stay zero as the boundary)
    logic [3*N-1:0] r_ref, r_qry;
    logic [7:0]     r_h   [0:N][0:N];
    logic [1:0]     r_ptr [0:N][0:N];

    logic [IW-1:0]  r_i, r_j, r_ti, r_tj;
    logic [IW-1:0]  r_best_i, r_best_j;
    logic [7:0]     r_best;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_buf_r, r_buf_q;

    // Control strobes from the FSM output process
    logic w_load, w_fill, w_trace, w_finish;

    // Fill datapath
    logic [IW-1:0]       w_im1, w_jm1;
    logic [2:0]          w_rb, w_qb;
    logic                w_match;
    logic signed [10:0]  w_cand_diag, w_cand_up, w_cand_left, w_max;
    logic [7:0]          w_h_new;
    logic [1:0]          w_ptr_new;
    logic                w_best_upd, w_last_col, w_last_cell;

    // Trace datapath
    logic [1:0]          w_tptr;
    logic                w_trace_end;
    logic [2:0]          w_sym_r, w_sym_q;

    // Base idx (1-based) of a packed sequence; index 0 has no base
    function automatic logic [2:0] f_base(input logic [3*N-1:0] seq, input logic [IW-1:0] idx);
        if (idx == '0 || int'(idx) > N)
            return SYM_PAD;
        return seq[3*(N-int'(idx)) +: 3];
    endfunction

    // First banded column of row i
    function automatic logic [IW-1:0] f_jlo(input logic [IW-1:0] i);
        return (int'(i) > BAND) ? IW'(int'(i) - BAND) : IW'(1);
    endfunction

    // Last banded column of row i
    function automatic logic [IW-1:0] f_jhi(input logic [IW-1:0] i);
        return (int'(i) + BAND < N) ? IW'(int'(i) + BAND) : IW'(N);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; start is only honoured when idle or done
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)       w_state_next = S_FILL;
            S_FILL:         if (w_last_cell) w_state_next = S_TRACE;
            S_TRACE:        if (w_trace_end) w_state_next = S_DONE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    // FSM output strobes driving the datapath
    always_comb begin
        w_load   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
        w_fill   = (r_state == S_FILL);
        w_trace  = (r_state == S_TRACE);
        w_finish = w_trace && w_trace_end;
    end

    // Cell score: max of zero, diagonal, up and left, with tie priority diag > up > left
    always_comb begin
        w_im1       = r_i - 1'b1;
        w_jm1       = r_j - 1'b1;
        w_rb        = f_base(r_ref, r_i);
        w_qb        = f_base(r_qry, r_j);
        w_match     = !w_rb[2] && (w_rb == w_qb);
        w_cand_diag = w_match ? (11'(r_h[w_im1][w_jm1]) + 11'(MATCH))
                              : (11'(r_h[w_im1][w_jm1]) - 11'(MISMATCH));
        w_cand_up   = 11'(r_h[w_im1][r_j]) - 11'(GAP);
        w_cand_left = 11'(r_h[r_i][w_jm1]) - 11'(GAP);
        w_max       = 11'sd0;
        if (w_cand_diag > w_max) w_max = w_cand_diag;
        if (w_cand_up   > w_max) w_max = w_cand_up;
        if (w_cand_left > w_max) w_max = w_cand_left;
        if (w_max == 11'sd0)
            w_ptr_new = P_STOP;
        else if (w_max == w_cand_diag)
            w_ptr_new = P_DIAG;
        else if (w_max == w_cand_up)
            w_ptr_new = P_UP;
        else
            w_ptr_new = P_LEFT;
        w_h_new     = (w_max > 11'sd255) ? 8'hFF : w_max[7:0];
        w_best_upd  = (w_h_new > r_best);
        w_last_col  = (r_j == f_jhi(r_i));
        w_last_cell = w_last_col && (r_i == IW'(N));
    end

    // Traceback step: pick the symbol pair for the current pointer
    always_comb begin
        w_tptr      = r_ptr[r_ti][r_tj];
        w_trace_end = (r_ti == '0) || (r_tj == '0) || (w_tptr == P_STOP) || (r_cnt == CW'(AL));
        w_sym_r     = (w_tptr == P_LEFT) ? SYM_GAP : f_base(r_ref, r_ti);
        w_sym_q     = (w_tptr == P_UP)   ? SYM_GAP : f_base(r_qry, r_tj);
    end

    // Score/pointer matrix: cleared on start so out-of-band cells read as zero
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int a = 0; a <= N; a++) begin
                for (int b = 0; b <= N; b++) begin
                    r_h[a][b]   <= 8'd0;
                    r_ptr[a][b] <= P_STOP;
                end
            end
        end else if (w_fill) begin
            r_h[r_i][r_j]   <= w_h_new;
            r_ptr[r_i][r_j] <= w_ptr_new;
        end
    end

    // Sequencing, best-cell tracking, traceback buffers and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ref     <= '0;
            r_qry     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_ti      <= '0;
            r_tj      <= '0;
            r_best    <= '0;
            r_best_i  <= '0;
            r_best_j  <= '0;
            r_cnt     <= '0;
            r_buf_r   <= '1;
            r_buf_q   <= '1;
            R_aligned <= '1;
            Q_aligned <= '1;
            pe_mem    <= '0;
            ready     <= 1'b0;
        end else if (w_load) begin
            r_ref    <= R;
            r_qry    <= Q;
            r_i      <= IW'(1);
            r_j      <= IW'(1);
            r_best   <= '0;
            r_best_i <= '0;
            r_best_j <= '0;
            ready    <= 1'b0;
        end else if (w_fill) begin
            if (w_best_upd) begin
                r_best   <= w_h_new;
                r_best_i <= r_i;
                r_best_j <= r_j;
            end
            if (w_last_col) begin
                r_i <= r_i + 1'b1;
                r_j <= f_jlo(r_i + 1'b1);
            end else begin
                r_j <= r_j + 1'b1;
            end
            // Seed the traceback with the best cell including this last one
            if (w_last_cell) begin
                r_ti    <= w_best_upd ? r_i : r_best_i;
                r_tj    <= w_best_upd ? r_j : r_best_j;
                r_cnt   <= '0;
                r_buf_r <= '1;
                r_buf_q <= '1;
            end
        end else if (w_trace) begin
            if (w_trace_end) begin
                R_aligned <= r_buf_r;
                Q_aligned <= r_buf_q;
                pe_mem    <= {4'(r_best_i), 4'(r_best_j)};
                ready     <= 1'b1;
            end else begin
                // Newest symbol enters at position 0, so the alignment ends up left-justified
                r_buf_r <= {w_sym_r, r_buf_r[AW-1:3]};
                r_buf_q <= {w_sym_q, r_buf_q[AW-1:3]};
                r_cnt   <= r_cnt + 1'b1;
                if (w_tptr != P_LEFT) r_ti <= r_ti - 1'b1;
                if (w_tptr != P_UP)   r_tj <= r_tj - 1'b1;
            end
        end
    end

`ifdef BSW_SCORE_PORT_EN
    // Best score is published together with the aligned result
    always_ff @(posedge clk) begin
        if (!reset)
            best_score <= '0;
        else if (w_finish)
            best_score <= r_best;
    end
`endif

endmodule

// File: tb/tb_banded_sw_aligner.sv
// Scoreboard bench for banded_sw_aligner: stimulus pushes expected results,
// a monitor pops and compares on every rising edge of ready.
module tb_banded_sw_aligner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] R = '0;
    logic [23:0] Q = '0;
    logic [29:0] R_aligned, Q_aligned;
    logic        ready;
    logic [7:0]  pe_mem;
`ifdef BSW_SCORE_PORT_EN
    logic [7:0]  best_score;
`endif

    banded_sw_aligner dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .R         (R),
        .Q         (Q),
        .R_aligned (R_aligned),
        .Q_aligned (Q_aligned),
        .ready     (ready),
`ifdef BSW_SCORE_PORT_EN
        .best_score(best_score),
`endif
        .pe_mem    (pe_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] ra;
        logic [29:0] qa;
        logic [7:0]  pe;
        logic [7:0]  sc;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_res   = 0;
    logic prev_ready = 1'b0;

    function automatic logic [2:0] enc(input byte c);
        case (c)
            "A": return 3'b000;
            "C": return 3'b001;
            "G": return 3'b010;
            "T": return 3'b011;
            "-": return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    // Pack a symbol string, first character in the most significant slot
    function automatic logic [29:0] pack(input string s);
        logic [29:0] v = '0;
        for (int k = 0; k < s.len(); k++)
            v = {v[26:0], enc(s[k])};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string ra, input string qa, input logic [7:0] pe, input logic [7:0] sc);
        exp_t e;
        e.ra = pack(ra);
        e.qa = pack(qa);
        e.pe = pe;
        e.sc = sc;
        q_exp.push_back(e);
    endtask

    // Pulse start with the given pair, then scramble the inputs to prove they were latched
    task automatic issue(input string rs, input string qs);
        @(negedge clk);
        R = 24'(pack(rs));
        Q = 24'(pack(qs));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        R = 24'($urandom);
        Q = 24'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!ready) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout: ready=%b after %0d cycles, required 1 within 60", name, ready, n);
        end
        @(negedge clk);
    endtask

    // Monitor: compare each presented result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready && !prev_ready) begin
                if (q_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_result: pe_mem=%h with no result expected", pe_mem);
                end else begin
                    e = q_exp.pop_front();
                    n_res++;
                    check("R_aligned", 32'(R_aligned), 32'(e.ra));
                    check("Q_aligned", 32'(Q_aligned), 32'(e.qa));
                    check("pe_mem", 32'(pe_mem), 32'(e.pe));
`ifdef BSW_SCORE_PORT_EN
                    check("best_score", 32'(best_score), 32'(e.sc));
`endif
                    $display("[TB] result %0d: pe_mem=%h R_aligned=%h Q_aligned=%h", n_res, pe_mem, R_aligned, Q_aligned);
                end
            end
            prev_ready = ready;
        end
    end

    // Stimulus
    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pe_mem", 32'(pe_mem), 32'h00);
        check("rst_R_aligned", 32'(R_aligned), 32'h3FFFFFFF);
        check("rst_Q_aligned", 32'(Q_aligned), 32'h3FFFFFFF);
        reset = 1'b1;

        // Identical sequences: full-length diagonal
        push("ACGTACGT..", "ACGTACGT..", 8'h88, 8'd16);
        issue("ACGTACGT", "ACGTACGT");
        wait_done("identical");

        // Single mismatch, no gaps
        push("ACGTACGT..", "ACGAACGT..", 8'h88, 8'd13);
        issue("ACGTACGT", "ACGAACGT");
        wait_done("mismatch");

        // One gap in the query
        push("ACGTACGT..", "ACG-ACGT..", 8'h87, 8'd13);
        issue("ACGTACGT", "ACGACGTT");
        wait_done("gap");

        // Nothing matches: empty alignment
        push("..........", "..........", 8'h00, 8'd0);
        issue("AAAAAAAA", "CCCCCCCC");
        wait_done("nomatch");

        // Local alignment on the band edge (query offset by BAND)
        push("ACG.......", "ACG.......", 8'h35, 8'd6);
        issue("ACGTTTTT", "GGACGGGG");
        wait_done("band_edge");

        // Second start during FILL must be ignored
        push("ACGTACGT..", "ACGTACGT..", 8'h88, 8'd16);
        issue("ACGTACGT", "ACGTACGT");
        repeat (5) @(negedge clk);
        R = 24'(pack("AAAAAAAA"));
        Q = 24'(pack("CCCCCCCC"));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_ignored");

        // Reset during FILL aborts and restores reset outputs
        issue("ACGTACGT", "ACGAACGT");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_pe_mem", 32'(pe_mem), 32'h00);
        check("abort_R_aligned", 32'(R_aligned), 32'h3FFFFFFF);
        check("abort_Q_aligned", 32'(Q_aligned), 32'h3FFFFFFF);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Normal run after the abort
        push("ACGTACGT..", "ACG-ACGT..", 8'h87, 8'd13);
        issue("ACGTACGT", "ACGACGTT");
        wait_done("after_abort");

        repeat (70) @(negedge clk);
        check("results_drained", 32'(q_exp.size()), 32'd0);
        check("result_count", 32'(n_res), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/banded_sw_aligner.md
Name: banded_sw_aligner

Overview:
- Banded Smith-Waterman local-alignment engine for two fixed-length DNA sequences: reference R and query Q.
- Captures R and Q on a start pulse, fills the banded DP score matrix, then traces back from the best-scoring cell.
- Outputs the gapped, aligned sequences plus the end coordinate of the alignment.
- Sits between a stimulus/sequence memory, which holds R and Q stable, and downstream result logic.

Parameters:
- N, 8: bases per input sequence. Fixes R/Q width to 3*N.
- BAND, 2: half-width of the band. Only cells with |i-j| <= BAND are computed. Aligned width is 3*(N+BAND).
- MATCH, 2: score added on a base match.
- MISMATCH, 1: penalty subtracted on a mismatch.
- GAP, 1: linear gap penalty per gap symbol.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches R/Q and begins alignment.
- R  in  24  reference sequence, 3 bits/base; base 0 at [23:21].
- Q  in  24  query sequence, same packing as R.
- R_aligned  out  30  aligned reference, 10 symbols; symbol 0 at [29:27].
- Q_aligned  out  30  aligned query, same packing as R_aligned.
- ready  out  1  high when the result is valid.
- pe_mem  out  8  {end_i[3:0], end_j[3:0]} of the traceback start cell (1-based).

Behaviour:
- Base encoding: A=000, C=001, G=010, T=011. Gap=100. Pad (unused output position)=111. Input codes 100-111 are treated as never matching anything.
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE.
  - ready=0, pe_mem=0x00, R_aligned and Q_aligned all 1s (all pad).
  - Reset overrides start and aborts any operation in progress.
- FSM states: IDLE -> FILL -> TRACE -> DONE.
  - IDLE/DONE + start=1: latch R and Q into internal registers, clear the score matrix, ready<=0, go to FILL.
  - start in FILL or TRACE: ignored.
  - DONE holds outputs and ready=1 until the next start or reset.
- Score recurrence:
  - H(i,0)=H(0,j)=0. Cells outside the band are read as 0.
  - H(i,j)=max(0, H(i-1,j-1)+s, H(i-1,j)-GAP, H(i,j-1)-GAP), where s=+MATCH on match and -MISMATCH otherwise.
  - Scores are unsigned 8-bit and saturate at 255.
- FILL:
  - Evaluates one banded cell per clock, row-major: i=1..N, j=max(1,i-BAND)..min(N,i+BAND). Default is 34 cells.
  - Stores a 2-bit pointer per cell: 00=stop (H=0), 01=diag, 10=up (gap in Q), 11=left (gap in R).
  - Pointer priority on ties: diag > up > left. Stop only when H=0.
  - Tracks the best cell; it updates only on strictly greater H, so the earliest row-major maximum wins.
- TRACE:
  - Starts at the best cell and emits one symbol pair per clock, walking pointers until stop or i=0 or j=0.
  - diag emits (R[i],Q[j]); up emits (R[i],gap); left emits (gap,Q[j]).
  - Symbols are produced in reverse order. The output is left-justified: alignment start is at symbol 0, and trailing positions are pad.
- End of TRACE:
  - pe_mem = {best_i, best_j}.
  - R_aligned and Q_aligned are updated together; ready<=1 in the same cycle; go to DONE.
- Best score 0 (no matching base): alignment is empty; outputs all pad, pe_mem=0x00, ready=1.
- Latency: start to ready <= 60 clocks at default parameters (34 FILL + <=10 TRACE + overhead).
- R and Q may change after the start cycle without affecting the result.

Optional Feature:
- Macro BSW_SCORE_PORT_EN.
- Defined: adds output port best_score [7:0] carrying the maximum H found. It resets to 0 and is valid when ready=1.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Test Plan:
- Reset low 2 cycles -> ready=0, pe_mem=0x00, R_aligned=Q_aligned=30'h3FFFFFFF.
- R=Q=ACGTACGT (24'o01230123), start pulse -> within 60 cycles ready=1, pe_mem=0x88. Both aligned outputs are symbols A,C,G,T,A,C,G,T,pad,pad. best_score=16 when BSW_SCORE_PORT_EN is defined.
- R=ACGTACGT, Q=ACGAACGT -> no gaps, pe_mem=0x88, score 13. Q_aligned is A,C,G,A,A,C,G,T,pad,pad.
- R=ACGTACGT, Q=ACGACGTT -> pe_mem=0x87, score 13. R_aligned=A,C,G,T,A,C,G,T,pad,pad. Q_aligned=A,C,G,gap,A,C,G,T,pad,pad.
- R=AAAAAAAA, Q=CCCCCCCC -> ready=1, pe_mem=0x00, outputs all pad.
- Mid-FILL: second start pulse is ignored (result matches the first pair). Mid-FILL reset low -> ready=0, outputs revert to reset values. A new start then completes normally.
